// File: rtl/glb_cgra_strm_bridge.sv
// Elastic stream bridge between the global buffer stream ports and the CGRA IO tiles:
// one FIFO per channel per direction plus a fixed-latency retimer on each control bit.
module glb_cgra_strm_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_vld,
    output logic                  o_rdy,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_vld,
    input  logic                  i_rdy,
    output logic [LVL_W-1:0]      o_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;

    assign w_full  = (r_count == LVL_W'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign o_rdy   = reset_n & ~w_full  & ~i_stall & ~i_flush;
    assign o_vld   = reset_n & ~w_empty & ~i_stall & ~i_flush;
    assign w_push  = i_vld & o_rdy;
    assign w_pop   = o_vld & i_rdy;
    assign o_data  = o_vld ? r_mem[r_rd_ptr] : '0;
    assign o_level = r_count;

    // Storage carries no reset; only the pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module glb_cgra_strm_bridge #(
    parameter int NUM_CH     = 32,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int CTRL_LAT   = 4
) (
    input  logic                                            clk,
    input  logic                                            reset_n,
    input  logic [NUM_CH-1:0]                               stall,
    input  logic [NUM_CH-1:0]                               flush,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                    g2f_in_data,
    input  logic [NUM_CH-1:0]                               g2f_in_vld,
    output logic [NUM_CH-1:0]                               g2f_in_rdy,
    input  logic [NUM_CH-1:0]                               g2f_in_ctrl,
    output logic [NUM_CH*DATA_WIDTH-1:0]                    g2f_out_data,
    output logic [NUM_CH-1:0]                               g2f_out_vld,
    input  logic [NUM_CH-1:0]                               g2f_out_rdy,
    output logic [NUM_CH-1:0]                               g2f_out_ctrl,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                    f2g_in_data,
    input  logic [NUM_CH-1:0]                               f2g_in_vld,
    output logic [NUM_CH-1:0]                               f2g_in_rdy,
    input  logic [NUM_CH-1:0]                               f2g_in_ctrl,
    output logic [NUM_CH*DATA_WIDTH-1:0]                    f2g_out_data,
    output logic [NUM_CH-1:0]                               f2g_out_vld,
    input  logic [NUM_CH-1:0]                               f2g_out_rdy,
    output logic [NUM_CH-1:0]                               f2g_out_ctrl,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]        g2f_level,
    output logic [NUM_CH*($clog2(FIFO_DEPTH)+1)-1:0]        f2g_level
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_CH-1:0] r_g2f_ctrl_p [CTRL_LAT];
    logic [NUM_CH-1:0] r_f2g_ctrl_p [CTRL_LAT];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        glb_cgra_strm_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH),
            .LVL_W     (LVL_W)
        ) u_g2f (
            .clk    (clk),
            .reset_n(reset_n),
            .i_stall(stall[c]),
            .i_flush(flush[c]),
            .i_data (g2f_in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .i_vld  (g2f_in_vld[c]),
            .o_rdy  (g2f_in_rdy[c]),
            .o_data (g2f_out_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .o_vld  (g2f_out_vld[c]),
            .i_rdy  (g2f_out_rdy[c]),
            .o_level(g2f_level[c*LVL_W +: LVL_W])
        );

        glb_cgra_strm_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH),
            .LVL_W     (LVL_W)
        ) u_f2g (
            .clk    (clk),
            .reset_n(reset_n),
            .i_stall(stall[c]),
            .i_flush(flush[c]),
            .i_data (f2g_in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .i_vld  (f2g_in_vld[c]),
            .o_rdy  (f2g_in_rdy[c]),
            .o_data (f2g_out_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .o_vld  (f2g_out_vld[c]),
            .i_rdy  (f2g_out_rdy[c]),
            .o_level(f2g_level[c*LVL_W +: LVL_W])
        );
    end

    // Control retimer: free-running shift, deliberately blind to handshake, stall and flush.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < CTRL_LAT; s++) begin
                r_g2f_ctrl_p[s] <= '0;
                r_f2g_ctrl_p[s] <= '0;
            end
        end else begin
            r_g2f_ctrl_p[0] <= g2f_in_ctrl;
            r_f2g_ctrl_p[0] <= f2g_in_ctrl;
            for (int s = 1; s < CTRL_LAT; s++) begin
                r_g2f_ctrl_p[s] <= r_g2f_ctrl_p[s-1];
                r_f2g_ctrl_p[s] <= r_f2g_ctrl_p[s-1];
            end
        end
    end

    assign g2f_out_ctrl = r_g2f_ctrl_p[CTRL_LAT-1];
    assign f2g_out_ctrl = r_f2g_ctrl_p[CTRL_LAT-1];
endmodule

// File: tb/tb_glb_cgra_strm_bridge.sv
// Directed bench for glb_cgra_strm_bridge with a per-path data scoreboard.
module tb_glb_cgra_strm_bridge;
    localparam int NUM_CH = 32;
    localparam int DW     = 16;
    localparam int DEPTH  = 4;
    localparam int LAT    = 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic                    clk;
    logic                    reset_n;
    logic [NUM_CH-1:0]       stall, flush;
    logic [NUM_CH*DW-1:0]    g2f_in_data, f2g_in_data;
    logic [NUM_CH-1:0]       g2f_in_vld, g2f_in_rdy, g2f_in_ctrl;
    logic [NUM_CH*DW-1:0]    g2f_out_data, f2g_out_data;
    logic [NUM_CH-1:0]       g2f_out_vld, g2f_out_rdy, g2f_out_ctrl;
    logic [NUM_CH-1:0]       f2g_in_vld, f2g_in_rdy, f2g_in_ctrl;
    logic [NUM_CH-1:0]       f2g_out_vld, f2g_out_rdy, f2g_out_ctrl;
    logic [NUM_CH*LVL_W-1:0] g2f_level, f2g_level;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb_g2f [NUM_CH][$];
    logic [DW-1:0] sb_f2g [NUM_CH][$];

    glb_cgra_strm_bridge #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CTRL_LAT(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .g2f_in_data(g2f_in_data), .g2f_in_vld(g2f_in_vld), .g2f_in_rdy(g2f_in_rdy),
        .g2f_in_ctrl(g2f_in_ctrl), .g2f_out_data(g2f_out_data), .g2f_out_vld(g2f_out_vld),
        .g2f_out_rdy(g2f_out_rdy), .g2f_out_ctrl(g2f_out_ctrl),
        .f2g_in_data(f2g_in_data), .f2g_in_vld(f2g_in_vld), .f2g_in_rdy(f2g_in_rdy),
        .f2g_in_ctrl(f2g_in_ctrl), .f2g_out_data(f2g_out_data), .f2g_out_vld(f2g_out_vld),
        .f2g_out_rdy(f2g_out_rdy), .f2g_out_ctrl(f2g_out_ctrl),
        .g2f_level(g2f_level), .f2g_level(f2g_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LVL_W-1:0] lvl_g(input int c);
        return g2f_level[c*LVL_W +: LVL_W];
    endfunction

    function automatic logic [LVL_W-1:0] lvl_f(input int c);
        return f2g_level[c*LVL_W +: LVL_W];
    endfunction

    // Scoreboard: record accepted words, compare every emitted word against the oldest one.
    task automatic sb_monitor();
        for (int c = 0; c < NUM_CH; c++) begin
            if (!reset_n || flush[c]) begin
                sb_g2f[c].delete();
                sb_f2g[c].delete();
            end else begin
                if (g2f_out_vld[c] && g2f_out_rdy[c]) begin
                    if (sb_g2f[c].size() == 0) chk("g2f_unexpected_word", 64'(c), 64'hFFFF);
                    else chk("g2f_data", 64'(g2f_out_data[c*DW +: DW]), 64'(sb_g2f[c].pop_front()));
                end
                if (f2g_out_vld[c] && f2g_out_rdy[c]) begin
                    if (sb_f2g[c].size() == 0) chk("f2g_unexpected_word", 64'(c), 64'hFFFF);
                    else chk("f2g_data", 64'(f2g_out_data[c*DW +: DW]), 64'(sb_f2g[c].pop_front()));
                end
                if (g2f_in_vld[c] && g2f_in_rdy[c]) sb_g2f[c].push_back(g2f_in_data[c*DW +: DW]);
                if (f2g_in_vld[c] && f2g_in_rdy[c]) sb_f2g[c].push_back(f2g_in_data[c*DW +: DW]);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sz;
        reset_n = 1'b0; stall = '0; flush = '0;
        g2f_in_data = '0; g2f_in_vld = '0; g2f_in_ctrl = '0; g2f_out_rdy = '0;
        f2g_in_data = '0; f2g_in_vld = '0; f2g_in_ctrl = '0; f2g_out_rdy = '0;
        @(posedge clk); #1;

        // Reset
        #1;
        chk("rst_g2f_in_rdy", 64'(g2f_in_rdy), 64'h0);
        chk("rst_f2g_in_rdy", 64'(f2g_in_rdy), 64'h0);
        tick();
        chk("rst_g2f_out_vld", 64'(g2f_out_vld), 64'h0);
        chk("rst_f2g_out_vld", 64'(f2g_out_vld), 64'h0);
        chk("rst_out_ctrl", 64'({g2f_out_ctrl, f2g_out_ctrl}), 64'h0);
        chk("rst_g2f_level", 64'(g2f_level), 64'h0);
        chk("rst_f2g_level", 64'(f2g_level), 64'h0);
        chk("rst_out_data", 64'(g2f_out_data[DW-1:0]), 64'h0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("rel_g2f_in_rdy", 64'(g2f_in_rdy), 64'hFFFF_FFFF);
        chk("rel_f2g_in_rdy", 64'(f2g_in_rdy), 64'hFFFF_FFFF);
        tick();

        // Preload ch1 g2f with two words, its consumer blocked
        g2f_out_rdy = ~32'h2;
        g2f_in_vld[1] = 1'b1;
        g2f_in_data[1*DW +: DW] = 16'h1111; tick();
        g2f_in_data[1*DW +: DW] = 16'h2222; tick();
        g2f_in_data[1*DW +: DW] = 16'h3333;
        stall[1] = 1'b1;

        // Stream ch0 while ch1 is stalled
        for (int i = 0; i < 16; i++) begin
            g2f_in_vld[0] = 1'b1;
            g2f_in_data[0 +: DW] = 16'(i + 1);
            #1;
            chk("strm_in_rdy", 64'(g2f_in_rdy[0]), 64'h1);
            chk("strm_out_vld", 64'(g2f_out_vld[0]), (i == 0) ? 64'h0 : 64'h1);
            chk("strm_level", 64'(lvl_g(0)), (i == 0) ? 64'h0 : 64'h1);
            chk("stall_in_rdy", 64'(g2f_in_rdy[1]), 64'h0);
            chk("stall_level", 64'(lvl_g(1)), 64'h2);
            tick();
        end
        g2f_in_vld[0] = 1'b0;
        #1;
        chk("strm_last_vld", 64'(g2f_out_vld[0]), 64'h1);
        tick();
        chk("strm_done_vld", 64'(g2f_out_vld[0]), 64'h0);
        chk("strm_done_level", 64'(lvl_g(0)), 64'h0);

        // Unstall ch1, push third word, then flush
        stall[1] = 1'b0;
        tick();
        g2f_in_vld[1] = 1'b0;
        #1;
        chk("pre_flush_level", 64'(lvl_g(1)), 64'h3);
        g2f_out_rdy[1] = 1'b1;
        flush[1] = 1'b1;
        #1;
        chk("flush_out_vld", 64'(g2f_out_vld[1]), 64'h0);
        chk("flush_in_rdy", 64'(g2f_in_rdy[1]), 64'h0);
        tick();
        flush[1] = 1'b0;
        #1;
        chk("post_flush_level", 64'(lvl_g(1)), 64'h0);
        chk("post_flush_vld", 64'(g2f_out_vld[1]), 64'h0);
        g2f_in_vld[1] = 1'b1;
        g2f_in_data[1*DW +: DW] = 16'hABCD;
        tick();
        g2f_in_vld[1] = 1'b0;
        #1;
        chk("abcd_vld", 64'(g2f_out_vld[1]), 64'h1);
        chk("abcd_data", 64'(g2f_out_data[1*DW +: DW]), 64'hABCD);
        tick();
        chk("abcd_alone", 64'(g2f_out_vld[1]), 64'h0);

        // Flush beats stall and a pending push
        g2f_out_rdy[1] = 1'b0;
        g2f_in_vld[1] = 1'b1;
        g2f_in_data[1*DW +: DW] = 16'h0101; tick();
        g2f_in_data[1*DW +: DW] = 16'h0202; tick();
        g2f_in_data[1*DW +: DW] = 16'h5555;
        flush[1] = 1'b1; stall[1] = 1'b1;
        #1;
        chk("prio_level_before", 64'(lvl_g(1)), 64'h2);
        chk("prio_in_rdy", 64'(g2f_in_rdy[1]), 64'h0);
        tick();
        flush[1] = 1'b0; stall[1] = 1'b0; g2f_in_vld[1] = 1'b0;
        #1;
        chk("prio_level_after", 64'(lvl_g(1)), 64'h0);
        chk("prio_out_vld", 64'(g2f_out_vld[1]), 64'h0);

        // Backpressure on f2g ch3
        f2g_out_rdy = '1;
        f2g_out_rdy[3] = 1'b0;
        f2g_in_vld[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            f2g_in_data[3*DW +: DW] = 16'(16'hA0 + i);
            #1;
            chk("bp_in_rdy", 64'(f2g_in_rdy[3]), 64'h1);
            tick();
        end
        f2g_in_data[3*DW +: DW] = 16'hA4;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("bp_full_rdy", 64'(f2g_in_rdy[3]), 64'h0);
            chk("bp_full_level", 64'(lvl_f(3)), 64'h4);
            tick();
        end
        f2g_out_rdy[3] = 1'b1;
        #1;
        chk("bp_release_rdy0", 64'(f2g_in_rdy[3]), 64'h0);
        chk("bp_drain_vld0", 64'(f2g_out_vld[3]), 64'h1);
        tick();
        chk("bp_release_rdy1", 64'(f2g_in_rdy[3]), 64'h1);
        tick();
        f2g_in_vld[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_drain_vld", 64'(f2g_out_vld[3]), 64'h1);
            tick();
        end
        chk("bp_drain_done", 64'(f2g_out_vld[3]), 64'h0);

        // Control latency, free and stalled
        for (int pass = 0; pass < 2; pass++) begin
            stall[2] = (pass == 1);
            g2f_in_ctrl[2] = 1'b1;
            f2g_in_ctrl[5] = (pass == 1);
            tick();
            g2f_in_ctrl[2] = 1'b0;
            f2g_in_ctrl[5] = 1'b0;
            for (int k = 1; k <= LAT + 2; k++) begin
                #1;
                chk("ctrl_g2f", 64'(g2f_out_ctrl[2]), (k == LAT) ? 64'h1 : 64'h0);
                if (pass == 1) chk("ctrl_f2g", 64'(f2g_out_ctrl[5]), (k == LAT) ? 64'h1 : 64'h0);
                tick();
            end
            stall[2] = 1'b0;
        end

        // Reset mid-transfer discards buffered data
        f2g_out_rdy[7] = 1'b0;
        f2g_in_vld[7] = 1'b1;
        f2g_in_data[7*DW +: DW] = 16'h7777;
        tick();
        f2g_in_vld[7] = 1'b0;
        #1;
        chk("mid_level", 64'(lvl_f(7)), 64'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rdy", 64'(f2g_in_rdy[7]), 64'h0);
        chk("mid_rst_vld", 64'(f2g_out_vld[7]), 64'h0);
        tick();
        reset_n = 1'b1;
        f2g_out_rdy[7] = 1'b1;
        #1;
        chk("mid_after_level", 64'(lvl_f(7)), 64'h0);
        chk("mid_after_vld", 64'(f2g_out_vld[7]), 64'h0);
        chk("mid_after_rdy", 64'(f2g_in_rdy), 64'hFFFF_FFFF);

        // Drain everything and confirm nothing was left unaccounted for
        g2f_out_rdy = '1;
        f2g_out_rdy = '1;
        for (int k = 0; k < 8; k++) tick();
        sz = 0;
        for (int c = 0; c < NUM_CH; c++) sz += sb_g2f[c].size() + sb_f2g[c].size();
        chk("sb_residue", 64'(sz), 64'h0);
        chk("final_out_vld", 64'({g2f_out_vld, f2g_out_vld}), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/glb_cgra_strm_bridge.md
# glb_cgra_strm_bridge

Synthesizable, parametrised streaming bridge between the global buffer's stream ports and the CGRA IO tiles. It replaces the fixed-delay, unbuffered wiring between the two with per-channel elastic FIFOs, one in each direction. Each channel also has a fixed-latency control-bit retimer and per-channel stall and flush controls. It sits between `global_buffer` (`strm_*_g2f` / `strm_*_f2g`) and the CGRA `io16_*` / `io1_*` ports.

## Interface
Parameters:
- NUM_CH, 32 — number of stream channels (NUM_GLB_TILES*CGRA_PER_GLB).
- DATA_WIDTH, 16 — stream word width (CGRA_DATA_WIDTH).
- FIFO_DEPTH, 4 — entries per channel per direction; power of two, ≥2.
- CTRL_LAT, 4 — register stages on each control bit; ≥1.

Ports:
- clk  in  1  — single clock for all state.
- reset_n  in  1  — synchronous, active-low reset.
- stall  in  NUM_CH  — per-channel freeze, both directions.
- flush  in  NUM_CH  — per-channel FIFO clear, both directions.
- g2f_in_data  in  NUM_CH×DATA_WIDTH  — words from the GLB.
- g2f_in_vld  in  NUM_CH  — GLB word valid.
- g2f_in_rdy  out  NUM_CH  — bridge can accept a GLB word.
- g2f_in_ctrl  in  NUM_CH  — GLB control bit.
- g2f_out_data  out  NUM_CH×DATA_WIDTH  — words to the CGRA.
- g2f_out_vld  out  NUM_CH  — word to the CGRA is valid.
- g2f_out_rdy  in  NUM_CH  — CGRA can accept a word.
- g2f_out_ctrl  out  NUM_CH  — retimed control bit to the CGRA.
- f2g_in_data, f2g_in_vld, f2g_in_rdy, f2g_in_ctrl, f2g_out_data, f2g_out_vld, f2g_out_rdy, f2g_out_ctrl — same widths and roles as the g2f ports, carrying traffic from the CGRA to the GLB.
- g2f_level, f2g_level  out  NUM_CH×($clog2(FIFO_DEPTH)+1)  — current FIFO occupancy per channel.

## Operation
- Each of the 2×NUM_CH paths is an independent FIFO with a read pointer, a write pointer and an occupancy count. Pointers wrap modulo FIFO_DEPTH.
- Port equations for one path:
  - in_rdy = reset_n & !full & !stall & !flush.
  - out_vld = reset_n & !empty & !stall & !flush.
- Push occurs when in_vld & in_rdy. Pop occurs when out_vld & out_rdy.
- A push and a pop may occur in the same cycle. Occupancy is then unchanged and both pointers advance.
- full means occupancy == FIFO_DEPTH. No push is possible when full, because in_rdy = 0; there is no fall-through on a full FIFO.
- out_data = mem[rd_ptr] when out_vld = 1, otherwise 0.
- Words leave each path in arrival order. No word is dropped or duplicated.
- stall[c]: both paths of channel c accept and emit nothing. Contents and pointers are held.
- flush[c]: both paths of channel c have occupancy and pointers reset to 0 at the next edge. Data in flight in those FIFOs is discarded.
- flush has priority over stall and over any push or pop in the same cycle.
- Control bits: each ctrl input passes through a CTRL_LAT-deep shift register. The shift register ignores valid/ready, stall and flush.
- Reset (reset_n = 0 at an edge): all pointers, counts and ctrl shift registers clear to 0. FIFO memory contents are don't-care.
- Reset mid-transfer discards all buffered words.

## Timing
- Values of every output while and after reset_n = 0:
  - in_rdy = 0 and out_vld = 0 combinationally while reset_n = 0.
  - out_data = 0, out_ctrl = 0, level = 0.
  - In the first cycle with reset_n = 1 and no stall or flush, in_rdy = 1.
- Data latency: a word pushed at edge N appears with out_vld = 1 in the cycle after edge N. Minimum in-to-out latency is 1 cycle.
- Throughput: 1 word/cycle per path while out_rdy = 1.
- Backpressure: with out_rdy held at 0, in_rdy falls in the cycle after the FIFO_DEPTH-th push. The cycle after the first pop, in_rdy = 1 again.
- level updates one cycle after the push, pop or flush edge.
- Control latency: out_ctrl at cycle N+CTRL_LAT equals in_ctrl sampled at cycle N.
- Stall and flush act combinationally on in_rdy and out_vld in the same cycle they are asserted. Their state effect takes place at the next edge.

## Test plan
- Reset: reset_n=0 for 2 cycles → all in_rdy/out_vld/out_ctrl/level = 0; first cycle after release → all in_rdy = 1.
- Stream, ch0 g2f, out_rdy=1: push 0x0001..0x0010 on 16 consecutive cycles → out_vld high for 16 consecutive cycles starting 1 cycle after the first push; data in order; level never exceeds 1.
- Backpressure, FIFO_DEPTH=4, f2g ch3: out_rdy=0 and push 0xA0..0xA4 → 0xA0..0xA3 accepted; in_rdy=0 while 0xA4 is held; level=4. Set out_rdy=1 → 0xA0..0xA4 emerge in order with no gap.
- Control, CTRL_LAT=4: single-cycle g2f_in_ctrl[2]=1 at cycle 10 → g2f_out_ctrl[2]=1 in cycle 14 only; also holds with stall[2]=1.
- Flush: 3 words buffered on ch1 g2f, flush[1] for 1 cycle → out_vld=0 that cycle; level=0 the next cycle. Later push 0xABCD → it emerges alone.
- Isolation and priority: stall[1]=1 while ch0 streams → ch1 level held and ch0 unaffected. flush[1]=stall[1]=1 with in_vld=1 → no push; level becomes 0.
